// File: rtl/inst_ram_pipe_pkg.sv
// Shared constants for the instruction RAM slice.
//   InstMemNum / InstMemNumLog2 : default instruction-word count and its log2
//   ZeroInst                    : all-zero instruction used on idle/error responses
//   RstEnable                   : asserted level of the asynchronous reset (active low)
//   is_pow2()                   : elaboration-time parameter check helper
package inst_ram_pipe_pkg;

  localparam int unsigned InstMemNum     = 1024;
  localparam int unsigned InstMemNumLog2 = $clog2(InstMemNum);
  localparam int unsigned InstWidth      = 64;

  localparam logic [InstWidth-1:0] ZeroInst  = '0;
  localparam logic                 RstEnable = 1'b0;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/inst_ram_core.sv
// Instruction storage array: one registered read port, one write port.
//   clk      : clock
//   rd_en    : load rd_data from mem[rd_idx] on this edge
//   rd_idx   : read word index
//   rd_data  : registered read data (read-first on a same-word write)
//   wr_en    : write mem[wr_idx] <= wr_data on this edge
//   wr_idx   : write word index
//   wr_data  : write data
// INIT_FILE is accepted for interface compatibility; contents start undefined.
module inst_ram_core #(
  parameter int unsigned INST_W    = 64,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned IDX_W     = $clog2(DEPTH),
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [INST_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [INST_W-1:0] wr_data
);

  logic [INST_W-1:0] mem [DEPTH];

  // rd_data only reloads on an accepted read, so it also serves as the
  // hold register that keeps the response stable while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/inst_ram_pipe.sv
// Pipelined instruction RAM for the IF stage.
//   clk, rst            : clock, asynchronous active-low reset
//   ce                  : chip enable (0 blocks new fetches, in-flight ones drain)
//   req_valid/req_ready : fetch request handshake, req_addr is a byte address
//   stall, flush        : downstream hold / discard all in-flight fetches
//   rsp_valid, rsp_inst, rsp_addr, rsp_misalign, rsp_oob : response, READ_LAT cycles later
//   wr_en, wr_addr, wr_data : load port (bad addresses are dropped)
module inst_ram_pipe
  import inst_ram_pipe_pkg::*;
#(
  parameter int unsigned INST_W    = InstWidth,
  parameter int unsigned DEPTH     = InstMemNum,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned READ_LAT  = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              stall,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [INST_W-1:0] rsp_inst,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_misalign,
  output logic              rsp_oob,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data
);

  localparam int unsigned OFF_W = $clog2(INST_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TOP_W = OFF_W + IDX_W;

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("inst_ram_pipe: READ_LAT must be 1 or 2");
  end
  if (!is_pow2(INST_W) || INST_W < 32) begin : g_bad_width
    $error("inst_ram_pipe: INST_W must be a power of two, at least 32");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("inst_ram_pipe: DEPTH must be a power of two");
  end

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0] != '0;
  endfunction

  function automatic logic is_oob(input logic [ADDR_W-1:0] a);
    return (a >> TOP_W) != '0;
  endfunction

  logic              accept;
  logic              req_mis;
  logic              req_oob;
  logic              rd_en;
  logic              wr_ok;
  logic [INST_W-1:0] mem_q;

  assign req_ready = ce & ~stall & ~flush;
  assign accept    = req_valid & req_ready;
  assign req_mis   = is_misaligned(req_addr);
  assign req_oob   = is_oob(req_addr);
  assign rd_en     = accept & ~req_mis & ~req_oob;
  assign wr_ok     = wr_en & ~is_misaligned(wr_addr) & ~is_oob(wr_addr);

  inst_ram_core #(
    .INST_W    (INST_W),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_idx  (req_addr[TOP_W-1:OFF_W]),
    .rd_data (mem_q),
    .wr_en   (wr_ok),
    .wr_idx  (wr_addr[TOP_W-1:OFF_W]),
    .wr_data (wr_data)
  );

  // Stage 1: request side-band aligned with the core's registered read data.
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic              s1_mis;
  logic              s1_oob;
  logic [INST_W-1:0] s1_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_mis   <= 1'b0;
      s1_oob   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= req_addr;
        s1_mis  <= req_mis;
        s1_oob  <= req_oob;
      end
    end
  end

  // Errored fetches never read the array, so mem_q is stale for them.
  assign s1_inst = (s1_valid && !s1_mis && !s1_oob) ? mem_q : INST_W'(ZeroInst);

  if (READ_LAT == 2) begin : g_lat2
    logic              s2_valid;
    logic [ADDR_W-1:0] s2_addr;
    logic              s2_mis;
    logic              s2_oob;
    logic [INST_W-1:0] s2_inst;

    always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
        s2_valid <= 1'b0;
        s2_addr  <= '0;
        s2_mis   <= 1'b0;
        s2_oob   <= 1'b0;
        s2_inst  <= '0;
      end else if (flush) begin
        s2_valid <= 1'b0;
      end else if (!stall) begin
        s2_valid <= s1_valid;
        s2_addr  <= s1_addr;
        s2_mis   <= s1_valid & s1_mis;
        s2_oob   <= s1_valid & s1_oob;
        s2_inst  <= s1_inst;
      end
    end

    // s2_inst/flags may be stale after a flush, so gate them with s2_valid.
    assign rsp_valid    = s2_valid;
    assign rsp_addr     = s2_addr;
    assign rsp_inst     = s2_valid ? s2_inst : '0;
    assign rsp_misalign = s2_valid & s2_mis;
    assign rsp_oob      = s2_valid & s2_oob;
  end else begin : g_lat1
    assign rsp_valid    = s1_valid;
    assign rsp_addr     = s1_addr;
    assign rsp_inst     = s1_inst;
    assign rsp_misalign = s1_valid & s1_mis;
    assign rsp_oob      = s1_valid & s1_oob;
  end

endmodule
